l1_d_assoc_controller: RTL

Parametrised N-way set-associative, write-back L1 data-cache controller. It sits between the core's load/store port and the L2 request interface. It owns the tag, valid, dirty and LRU state. It resolves hits in the lookup cycle, evicts dirty victims before refilling, and supports a full write-back flush. Data arrays are external; this block only drives their `refill`/`update` strobes and way select.

---
 rtl/l1_d_pkg.sv | 16 +
 rtl/l1_d_lru.sv | 52 +++++
 rtl/l1_d_assoc_controller.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/l1_d_pkg.sv
// l1_d_pkg: shared FSM state encoding and width helpers for the L1 data-cache controller.
package l1_d_pkg;

    typedef enum logic [2:0] {IDLE, WRITEBACK, ALLOCATE, REFILL, FLUSH} state_t;

    function automatic int clog2(input int v);
        int r = 0;
        for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

    function automatic int way_bits(input int ways);
        return (clog2(ways) < 1) ? 1 : clog2(ways);
    endfunction

endpackage

// File: rtl/l1_d_lru.sv
// l1_d_lru: per-set, per-way age counters; reports the oldest way of the looked-up set.
module l1_d_lru
    import l1_d_pkg::*;
#(
    parameter int INDEX_W = 6,
    parameter int WAYS = 2,
    localparam int WAY_W = way_bits(WAYS)
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic [INDEX_W-1:0] index,
    output logic [WAY_W-1:0]   victim,
    input  logic               access,
    input  logic [INDEX_W-1:0] access_index,
    input  logic [WAY_W-1:0]   access_way
);

    localparam int SETS = 2 ** INDEX_W;

    logic [WAY_W-1:0] age [SETS][WAYS];
    logic [WAY_W-1:0] best;

    // Ties resolve to the lowest-numbered way.
    always_comb begin
        victim = '0;
        best = age[index][0];
        for (int w = 1; w < WAYS; w++) begin
            if (age[index][w] > best) begin
                best = age[index][w];
                victim = WAY_W'(w);
            end
        end
    end

    // Ways no older than the accessed one age by one, saturating, so a set
    // that starts all-zero still settles into a strict recency order.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    age[s][w] <= '0;
        end else if (access) begin
            for (int w = 0; w < WAYS; w++) begin
                if (WAY_W'(w) == access_way)
                    age[access_index][w] <= '0;
                else if (age[access_index][w] <= age[access_index][access_way] && age[access_index][w] != '1)
                    age[access_index][w] <= age[access_index][w] + 1'b1;
            end
        end
    end

endmodule

// File: rtl/l1_d_assoc_controller.sv
// l1_d_assoc_controller: N-way set-associative write-back L1 D-cache controller
// owning tag/valid/dirty/LRU state; external data arrays follow refill/update/way.
module l1_d_assoc_controller
    import l1_d_pkg::*;
#(
    parameter int TAG_W = 52,
    parameter int INDEX_W = 6,
    parameter int WAYS = 2,
    localparam int WAY_W = way_bits(WAYS)
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic [TAG_W-1:0]   tag,
    input  logic [INDEX_W-1:0] index,
    input  logic               read_C_L1,
    input  logic               write_C_L1,
    input  logic               flush,
    output logic               stall,
    output logic               refill,
    output logic               update,
    output logic [WAY_W-1:0]   way,
    output logic [TAG_W-1:0]   wb_tag,
    output logic [INDEX_W-1:0] wb_index,
    output logic               read_L1_L2,
    output logic               write_L1_L2,
    input  logic               ready_L2_L1
);

    localparam int SETS = 2 ** INDEX_W;

    state_t state, state_n;
    logic [TAG_W-1:0]   tags [SETS][WAYS];
    logic [WAYS-1:0]    valid [SETS];
    logic [WAYS-1:0]    dirty [SETS];
    logic [WAY_W-1:0]   vic_way, hit_way, free_way, lru_way, f_way;
    logic [INDEX_W-1:0] vic_index, f_set;
    logic [TAG_W-1:0]   req_tag;
    logic req, lookup, hit, has_free, f_dirty, f_last, f_step, f_way_last;

    assign req = read_C_L1 | write_C_L1;
    assign lookup = (state == IDLE) && req && !flush;
    assign f_dirty = valid[f_set][f_way] & dirty[f_set][f_way];
    assign f_way_last = f_way == WAY_W'(WAYS - 1);
    assign f_last = (f_set == '1) && f_way_last;
    assign f_step = (state == FLUSH) && (!f_dirty || ready_L2_L1);

    // Descending scan so the lowest-numbered matching/free way wins.
    always_comb begin
        hit = 1'b0;
        hit_way = '0;
        has_free = 1'b0;
        free_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid[index][w] && tags[index][w] == tag) begin
                hit = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid[index][w]) begin
                has_free = 1'b1;
                free_way = WAY_W'(w);
            end
        end
    end

    l1_d_lru #(.INDEX_W(INDEX_W), .WAYS(WAYS)) u_lru (
        .clk(clk),
        .nrst(nrst),
        .index(index),
        .victim(lru_way),
        .access((lookup && hit) || state == REFILL),
        .access_index(state == REFILL ? vic_index : index),
        .access_way(state == REFILL ? vic_way : hit_way)
    );

    always_comb begin
        state_n = state;
        stall = 1'b1;
        update = 1'b0;
        refill = 1'b0;
        way = '0;
        wb_tag = '0;
        wb_index = '0;
        read_L1_L2 = 1'b0;
        write_L1_L2 = 1'b0;
        case (state)
            IDLE: begin
                stall = req && (flush || !hit);
                update = lookup && hit && write_C_L1;
                way = (lookup && hit) ? hit_way : '0;
                state_n = flush ? FLUSH
                        : !(lookup && !hit) ? IDLE
                        : (!has_free && dirty[index][lru_way]) ? WRITEBACK : ALLOCATE;
            end
            WRITEBACK: begin
                write_L1_L2 = 1'b1;
                way = vic_way;
                wb_tag = tags[vic_index][vic_way];
                wb_index = vic_index;
                state_n = ready_L2_L1 ? ALLOCATE : WRITEBACK;
            end
            ALLOCATE: begin
                read_L1_L2 = 1'b1;
                way = vic_way;
                state_n = ready_L2_L1 ? REFILL : ALLOCATE;
            end
            REFILL: begin
                refill = 1'b1;
                way = vic_way;
                state_n = IDLE;
            end
            FLUSH: begin
                write_L1_L2 = f_dirty;
                way = f_way;
                wb_tag = f_dirty ? tags[f_set][f_way] : '0;
                wb_index = f_dirty ? f_set : '0;
                state_n = (f_step && f_last) ? IDLE : FLUSH;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
            vic_way <= '0;
            vic_index <= '0;
            req_tag <= '0;
            f_set <= '0;
            f_way <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid[s] <= '0;
                dirty[s] <= '0;
            end
        end else begin
            state <= state_n;
            if (lookup && hit && write_C_L1)
                dirty[index][hit_way] <= 1'b1;
            if (lookup && !hit) begin
                vic_way <= has_free ? free_way : lru_way;
                vic_index <= index;
                req_tag <= tag;
            end
            if (state == WRITEBACK && ready_L2_L1)
                dirty[vic_index][vic_way] <= 1'b0;
            if (state == REFILL) begin
                valid[vic_index][vic_way] <= 1'b1;
                dirty[vic_index][vic_way] <= 1'b0;
            end
            if (f_step) begin
                valid[f_set][f_way] <= 1'b0;
                dirty[f_set][f_way] <= 1'b0;
                f_way <= f_way_last ? '0 : f_way + 1'b1;
                if (f_way_last)
                    f_set <= f_set + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == REFILL)
            tags[vic_index][vic_way] <= req_tag;
    end

endmodule
